// File: rtl/dpram_arb_pkg.sv
// rtl/dpram_arb_pkg.sv - shared defaults and pointer helpers for the dual-port RAM port arbiter
package dpram_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 6;
    localparam int DEF_DW   = 8;

    // Keeps ID fields at least one bit wide even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_ptr(input int cur, input int nreq);
        return (cur + 1 >= nreq) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a registered priority pointer
module rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] win;
    logic           found;

    // Scan from the pointer upward, wrapping modulo NREQ; first active request wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && !rst && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
        ptr_d = (advance && found) ? IDW'(next_ptr(int'(win), NREQ)) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - shares one RAM port among NREQ requesters with tagged read return
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_rdata,
    output logic               rd_valid,
    output logic [IDW-1:0]     rd_id,
    output logic [DW-1:0]      rd_data
);

    logic [NREQ-1:0] gnt_w;
    logic            xfer;
    logic [IDW-1:0]  win_id;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic            ram_we_q, ram_we_d;
    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt_w)
    );

    assign xfer = |gnt_w;

    always_comb begin
        win_id    = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_w[i]) begin
                win_id    = IDW'(i);
                win_we    = req_we[i];
                win_addr  = req_addr[i*AW +: AW];
                win_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Idle cycles keep the last address so the RAM just repeats a harmless read.
    always_comb begin
        ram_addr_d  = xfer ? win_addr : ram_addr_q;
        ram_wdata_d = xfer ? win_wdata : ram_wdata_q;
        ram_we_d    = xfer && win_we;
        s1_valid_d  = xfer && !win_we;
        s1_id_d     = win_id;
        s2_valid_d  = s1_valid_q;
        s2_id_d     = s1_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
        end
    end

    assign gnt       = gnt_w;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign rd_valid  = s2_valid_q;
    assign rd_id     = s2_id_q;
    assign rd_data   = ram_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - self-checking bench with RAM model and round-robin reference
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_we;
    logic [DW-1:0]      ram_rdata;
    logic               rd_valid;
    logic [IDW-1:0]     rd_id;
    logic [DW-1:0]      rd_data;

    logic               bd_we;
    logic [AW-1:0]      bd_addr;
    logic [DW-1:0]      bd_data;
    logic [DW-1:0]      mem [0:63];
    logic [DW-1:0]      ref_mem [0:63];

    int total = 0;
    int bad   = 0;

    int mptr;
    int m_we;
    int m_addr;
    int m_wd;
    int q_id[$];
    int q_data[$];
    int q_due[$];

    dpram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read (old data on same-edge write), plus a backdoor fill port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic set_req(input int i, input logic we, input int a, input int d);
        req[i]                  = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = AW'(a);
        req_wdata[i*DW +: DW]   = DW'(d);
    endtask

    task automatic backdoor(input int a, input int d);
        bd_we   = 1'b1;
        bd_addr = AW'(a);
        bd_data = DW'(d);
        ref_mem[a] = DW'(d);
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0; m_we = 0; m_addr = 0; m_wd = 0;
        q_id.delete(); q_data.delete(); q_due.delete();
    endtask

    task automatic drain(input int n);
        req = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        req = '1; req_we = '0; req_addr = '0; req_wdata = '0; bd_we = 1'b0;
        bd_addr = '0; bd_data = '0; rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_ram_addr got=%0d want=0", ram_addr); end
        total++; if (ram_wdata !== '0) begin bad++; $display("FAIL reset_ram_wdata got=%h want=00", ram_wdata); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if (rd_id !== '0) begin bad++; $display("FAIL reset_rd_id got=%0d want=0", rd_id); end
        req = '0;
        for (int a = 0; a < 64; a++) begin
            @(posedge clk); #1;
            bd_we = 1'b1; bd_addr = AW'(a); bd_data = DW'($urandom_range(0, 255));
            ref_mem[a] = bd_data;
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
        rst = 1'b0;
        mptr = 0; m_we = 0; m_addr = 0; m_wd = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (gnt !== '0) begin bad++; $display("FAIL idle_gnt got=%b want=0000", gnt); end
            total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL idle_ram_we got=%b want=0", ram_we); end
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid got=%b want=0", rd_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        backdoor(5, 8'hA5);
        req = '0;
        set_req(2, 1'b0, 5, 0);
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        total++; if (ram_addr !== 6'd5) begin bad++; $display("FAIL single_ram_addr got=%0d want=5", ram_addr); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL single_ram_we got=%b want=0", ram_we); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", rd_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%b want=1", rd_valid); end
        total++; if (rd_id !== 2'd2) begin bad++; $display("FAIL single_rd_id got=%0d want=2", rd_id); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_rd_data got=%h want=a5", rd_data); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", rd_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        backdoor(63, 8'hC3);
        req = '0;
        set_req(0, 1'b1, 63, 8'h3C);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b want=0001", gnt); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 63, 0);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rd_after_wr_gnt got=%b want=0001", gnt); end
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr_ram_we got=%b want=1", ram_we); end
        total++; if (ram_addr !== 6'd63) begin bad++; $display("FAIL wr_ram_addr got=%0d want=63", ram_addr); end
        total++; if (ram_wdata !== 8'h3C) begin bad++; $display("FAIL wr_ram_wdata got=%h want=3c", ram_wdata); end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rd_ram_we got=%b want=0", ram_we); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid got=%b want=0", rd_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b want=1", rd_valid); end
        total++; if (rd_id !== 2'd0) begin bad++; $display("FAIL wr_rd_id got=%0d want=0", rd_id); end
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL wr_rd_data got=%h want=3c", rd_data); end
        ref_mem[63] = 8'h3C;
        @(posedge clk); #1;
    endtask

    task automatic test_all_requesting();
        logic [NREQ-1:0] eg;
        int k;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 10 + i, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                eg = NREQ'(1 << (c % NREQ));
                total++; if (gnt !== eg) begin bad++; $display("FAIL all_gnt c=%0d got=%b want=%b", c, gnt, eg); end
            end
            if (c >= 2) begin
                k = (c - 2) % NREQ;
                total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL all_rd_valid c=%0d got=%b want=1", c, rd_valid); end
                total++; if (rd_id !== IDW'(k)) begin bad++; $display("FAIL all_rd_id c=%0d got=%0d want=%0d", c, rd_id, k); end
                total++; if (rd_data !== ref_mem[10 + k]) begin bad++; $display("FAIL all_rd_data c=%0d got=%h want=%h", c, rd_data, ref_mem[10 + k]); end
            end
            @(posedge clk); #1;
            if (c == 7) req = '0;
        end
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL all_tail got=%b want=0", rd_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] eg;
        do_reset();
        req = '0;
        set_req(1, 1'b0, 20, 0);
        set_req(3, 1'b0, 21, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            eg = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            total++; if (gnt !== eg) begin bad++; $display("FAIL fair_gnt c=%0d got=%b want=%b", c, gnt, eg); end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req = '0;
        set_req(1, 1'b0, 30, 0);
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt got=%b want=0010", gnt); end
        @(posedge clk); #1;
        req = '0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid c=%0d got=%b want=0", c, rd_valid); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr_gnt got=%b want=0001", gnt); end
        @(posedge clk); #1;
        drain(3);
    endtask

    task automatic test_random();
        logic p_act [NREQ];
        logic p_we  [NREQ];
        int   p_addr[NREQ];
        int   p_wd  [NREQ];
        logic [NREQ-1:0] eg;
        int k, idx, cyc;
        logic exp_v;
        do_reset();
        cyc = 0;
        for (int i = 0; i < NREQ; i++) p_act[i] = 1'b0;
        for (int n = 0; n < 404; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (n < 400 && !p_act[i] && $urandom_range(0, 1) == 1) begin
                    p_act[i]  = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = $urandom_range(0, 63);
                    p_wd[i]   = $urandom_range(0, 255);
                end
                if (p_act[i]) set_req(i, p_we[i], p_addr[i], p_wd[i]);
                else req[i] = 1'b0;
            end
            @(negedge clk);
            k = -1;
            for (int j = 0; j < NREQ; j++) begin
                idx = (mptr + j) % NREQ;
                if (k < 0 && p_act[idx]) k = idx;
            end
            eg = (k >= 0) ? NREQ'(1 << k) : '0;
            total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, gnt, eg); end
            total++; if (ram_we !== 1'(m_we)) begin bad++; $display("FAIL rnd_ram_we cyc=%0d got=%b want=%0d", cyc, ram_we, m_we); end
            total++; if (ram_addr !== AW'(m_addr)) begin bad++; $display("FAIL rnd_ram_addr cyc=%0d got=%0d want=%0d", cyc, ram_addr, m_addr); end
            total++; if (ram_wdata !== DW'(m_wd)) begin bad++; $display("FAIL rnd_ram_wdata cyc=%0d got=%h want=%h", cyc, ram_wdata, m_wd); end
            exp_v = (q_due.size() > 0 && q_due[0] == cyc);
            total++; if (rd_valid !== exp_v) begin bad++; $display("FAIL rnd_rd_valid cyc=%0d got=%b want=%b", cyc, rd_valid, exp_v); end
            if (exp_v) begin
                total++; if (rd_id !== IDW'(q_id[0])) begin bad++; $display("FAIL rnd_rd_id cyc=%0d got=%0d want=%0d", cyc, rd_id, q_id[0]); end
                total++; if (rd_data !== DW'(q_data[0])) begin bad++; $display("FAIL rnd_rd_data cyc=%0d got=%h want=%h", cyc, rd_data, q_data[0]); end
                void'(q_id.pop_front()); void'(q_data.pop_front()); void'(q_due.pop_front());
            end
            if (k >= 0) begin
                p_act[k] = 1'b0;
                mptr   = (k + 1) % NREQ;
                m_we   = int'(p_we[k]);
                m_addr = p_addr[k];
                m_wd   = p_wd[k];
                if (p_we[k]) ref_mem[p_addr[k]] = DW'(p_wd[k]);
                else begin
                    q_id.push_back(k);
                    q_data.push_back(int'(ref_mem[p_addr[k]]));
                    q_due.push_back(cyc + 2);
                end
            end else begin
                m_we = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_all_requesting();
        test_fairness();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter that shares one port of the 64x8 dual-port RAM between NREQ requesters. Each requester issues single-word reads or writes with a req/gnt handshake. The arbiter drives the RAM port through registered address, data and write-enable outputs. It returns read data tagged with the requester ID. One instance sits in front of each RAM port that needs sharing; the RAM itself is unchanged.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 8, RAM data width
- IDW, $clog2(NREQ), requester ID width

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; held until granted
- req_we  in  NREQ  per-requester write flag (1 = write, 0 = read)
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, combinational in the request cycle
- ram_addr  out  AW  to RAM port address, registered
- ram_wdata  out  DW  to RAM port input data, registered
- ram_we  out  1  to RAM port write enable, registered
- ram_rdata  in  DW  from RAM port output data (RAM-registered)
- rd_valid  out  1  read data valid, one-cycle pulse per granted read
- rd_id  out  IDW  requester index for rd_data
- rd_data  out  DW  equals ram_rdata, meaningful only when rd_valid=1

## Operation
- Handshake: a transfer occurs on any edge where req[i] & gnt[i] = 1. The requester keeps req_we, req_addr and req_wdata stable while req is high. It may drop req or issue the next request in the cycle after the grant.
- Arbitration: round-robin. The priority pointer ptr (IDW bits) names the highest-priority requester. The search runs ptr, ptr+1, … mod NREQ. The first active req wins.
- gnt is zero when no req is active. At most one gnt bit is set at any time. gnt never asserts for an inactive req.
- On a transfer by requester k, ptr becomes (k+1) mod NREQ. With no transfer, ptr holds.
- Transfer outputs: ram_addr, ram_wdata and ram_we load the winner's fields.
- Idle outputs: when there is no transfer, ram_we=0. ram_addr and ram_wdata hold their values, so the RAM performs a harmless read.
- Read pipeline: stage s1 (valid, id) captures reads at the transfer edge. Stage s2 captures s1 on the next edge.
  - rd_valid = s2_valid and rd_id = s2_id, both registered.
  - rd_data passes ram_rdata through combinationally.
- Writes produce no rd_valid and no acknowledgement beyond gnt.
- Back-to-back transfers: one transfer per cycle, sustained.
- Read data order matches grant order.
- Reset values: ptr=0, ram_addr=0, ram_wdata=0, ram_we=0, s1/s2 valid=0, s1/s2 id=0, rd_valid=0, rd_id=0. gnt=0 while rst is high.
- Reset mid-operation: all in-flight reads are discarded and no rd_valid is issued for them. Requesters reissue after reset.

## Timing
- Cycle t: req[k] is high, gnt[k] is high in the same cycle, and the edge at the end of t accepts the transfer.
- Cycle t+1: ram_addr, ram_we and ram_wdata present the request. The RAM samples it at the end of t+1.
- Cycle t+2: for reads, ram_rdata is valid and rd_valid=1 with rd_id=k. Read latency is 2 cycles from the grant cycle.
- For writes, RAM contents update at the end of t+1.
  - A read of the same address granted in cycle t+1 returns the new data in t+3.
- Wrap-around: ptr increments modulo NREQ. For example, NREQ-1 advances to 0.
- Simultaneous requests from all NREQ requesters are served in NREQ consecutive cycles, with no requester granted twice.

## Structure
- Shared package dpram_arb_pkg holds the AW, DW and NREQ defaults, the IDW derivation, and a "next pointer" function.
- Sub-module rr_arbiter (NREQ parameter) contains the ptr register and the one-hot grant logic. It has inputs req and advance, and output gnt.
- The top level holds the RAM-side registers and the two-stage read tag pipeline.

## Test plan
- Reset and idle:
  - Stimulus: rst pulse mid-cycle, then req=0.
  - Required: all outputs at their reset values, ram_we=0, gnt=0, no rd_valid.
- Single read:
  - Stimulus: preload addr 5 = 0xA5, then req[2] read of addr 5.
  - Required: gnt=0100 in cycle t; ram_addr=5 and ram_we=0 in t+1; rd_valid=1, rd_id=2, rd_data=0xA5 in t+2.
- Write then read:
  - Stimulus: req[0] writes 0x3C to addr 63, then req[0] reads addr 63 in the next cycle.
  - Required: rd_data=0x3C with rd_id=0.
- All requesting:
  - Stimulus: req=1111 held continuously, ptr=0 after reset.
  - Required: grants in order 0,1,2,3,0,…; a read-tagged sequence returns rd_id in the same order.
- Fairness and skip:
  - Stimulus: req=1010, ptr=0.
  - Required: grants 1,3,1,3; requesters 0 and 2 never granted.
- Reset mid-read:
  - Stimulus: read granted in t, rst asserted in t+1.
  - Required: no rd_valid in t+2 or later; ptr=0 after release.
